apb_master: RTL

- APB requester (initiator) that turns a simple valid/ready command port into APB SETUP/ACCESS transfers toward the codebase's APB slaves.
- Returns one response pulse per command, carrying read data, slave error and timeout status.
- Sits between a test/CPU-side command source and the APB bus.
- Handles exactly one outstanding transfer; no pipelining.

---
 rtl/apb_master.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/apb_master.sv
// APB requester: turns a valid/ready command into one SETUP/ACCESS transfer and a response pulse.
// Optional ACCESS-phase timeout abort is built when APB_MASTER_TIMEOUT_EN is defined.
module apb_master #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [WIDTH-1:0]      cmd_wdata,
  output logic                  rsp_valid,
  output logic [WIDTH-1:0]      rsp_rdata,
  output logic                  rsp_slverr,
  output logic                  rsp_timeout,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [WIDTH-1:0]      pwdata,
  input  logic [WIDTH-1:0]      prdata,
  input  logic                  pready,
  input  logic                  pslverr
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  logic [1:0]            state_q, state_d;
  logic                  psel_d, penable_d, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_d;
  logic [WIDTH-1:0]      pwdata_d;
  logic                  rsp_valid_d, rsp_slverr_d;
  logic [WIDTH-1:0]      rsp_rdata_d;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rsp_timeout_d;
`else
  assign rsp_timeout = 1'b0;
`endif

  // Ready only in IDLE and never while reset is asserted.
  assign cmd_ready = (state_q == ST_IDLE) && !preset;

  // Next-state and next-output logic.
  always_comb begin
    state_d       = state_q;
    psel_d        = psel;
    penable_d     = penable;
    pwrite_d      = pwrite;
    paddr_d       = paddr;
    pwdata_d      = pwdata;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata;
    rsp_slverr_d  = rsp_slverr;
`ifdef APB_MASTER_TIMEOUT_EN
    cnt_d         = cnt_q;
    rsp_timeout_d = rsp_timeout;
`endif
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          state_d   = ST_SETUP;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          pwrite_d  = cmd_write;
          paddr_d   = cmd_addr;
          pwdata_d  = cmd_wdata;
`ifdef APB_MASTER_TIMEOUT_EN
          cnt_d     = '0;
`endif
        end
      end
      ST_SETUP: begin
        state_d   = ST_ACCESS;
        penable_d = 1'b1;
      end
      ST_ACCESS: begin
        if (pready) begin
          state_d       = ST_IDLE;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_slverr_d  = pslverr;
          rsp_rdata_d   = pwrite ? '0 : prdata;
`ifdef APB_MASTER_TIMEOUT_EN
          rsp_timeout_d = 1'b0;
`endif
        end else begin
`ifdef APB_MASTER_TIMEOUT_EN
          // This edge is the TIMEOUT_CYCLES-th stalled ACCESS edge: abort.
          if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            state_d       = ST_IDLE;
            psel_d        = 1'b0;
            penable_d     = 1'b0;
            rsp_valid_d   = 1'b1;
            rsp_slverr_d  = 1'b1;
            rsp_rdata_d   = '0;
            rsp_timeout_d = 1'b1;
          end else if (cnt_q != CNT_W'(TIMEOUT_CYCLES)) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
`endif
        end
      end
      default: begin
        state_d   = ST_IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q     <= ST_IDLE;
      psel        <= 1'b0;
      penable     <= 1'b0;
      pwrite      <= 1'b0;
      paddr       <= '0;
      pwdata      <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_slverr  <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
      cnt_q       <= '0;
      rsp_timeout <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      psel        <= psel_d;
      penable     <= penable_d;
      pwrite      <= pwrite_d;
      paddr       <= paddr_d;
      pwdata      <= pwdata_d;
      rsp_valid   <= rsp_valid_d;
      rsp_rdata   <= rsp_rdata_d;
      rsp_slverr  <= rsp_slverr_d;
`ifdef APB_MASTER_TIMEOUT_EN
      cnt_q       <= cnt_d;
      rsp_timeout <= rsp_timeout_d;
`endif
    end
  end

endmodule
